// File: rtl/fifo_word_unpacker.sv
// Reads wide words from a single-clock FIFO and emits them as RATIO narrower
// sub-words (least-significant first) on a valid/ready stream.
module fifo_word_unpacker #(
  parameter int WORD_WDT = 64,
  parameter int RATIO    = 4,
  parameter int OUT_WDT  = WORD_WDT / RATIO
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                fifo_rd,
  input  logic                fifo_empty,
  input  logic [WORD_WDT-1:0] fifo_word,
  output logic [OUT_WDT-1:0]  out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last
);

  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  // Handshake: a beat transfers on a rising edge where out_valid & out_ready;
  // out_data/out_last hold while out_valid & !out_ready.

  logic [WORD_WDT-1:0] buf_q [2];
  logic [WORD_WDT-1:0] buf_d [2];
  logic [1:0]          occ_q, occ_d;
  logic                in_flight_q;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                xfer, pop;
  logic [2:0]          credit;

  assign out_valid = (occ_q != 2'd0);
  assign out_last  = out_valid && (idx_q == LAST_IDX);
  assign out_data  = buf_q[0][idx_q*OUT_WDT +: OUT_WDT];

  assign xfer = out_valid && out_ready;
  assign pop  = xfer && (idx_q == LAST_IDX);

  // Words already held or in flight, minus the one leaving this cycle, must
  // leave a free slot for the word a read issued now will deliver.
  assign credit  = {1'b0, occ_q} + {2'b00, in_flight_q} - {2'b00, pop};
  // Gated by rst_n so a non-empty FIFO is not popped while we are held in reset.
  assign fifo_rd = rst_n && !fifo_empty && (credit < 3'd2);

  always_comb begin
    buf_d[0] = buf_q[0];
    buf_d[1] = buf_q[1];
    occ_d    = occ_q;
    idx_d    = idx_q;
    if (pop) begin
      buf_d[0] = buf_q[1];
      occ_d    = occ_q - 2'd1;
    end
    if (in_flight_q) begin
      if (occ_d == 2'd0) buf_d[0] = fifo_word;
      else               buf_d[1] = fifo_word;
      occ_d = occ_d + 2'd1;
    end
    if (pop)       idx_d = '0;
    else if (xfer) idx_d = idx_q + IDX_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
      occ_q       <= 2'd0;
      in_flight_q <= 1'b0;
      idx_q       <= '0;
    end else begin
      buf_q[0]    <= buf_d[0];
      buf_q[1]    <= buf_d[1];
      occ_q       <= occ_d;
      in_flight_q <= fifo_rd;
      idx_q       <= idx_d;
    end
  end

`ifndef SYNTHESIS
  a_no_rd_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_rd && fifo_empty))
    else $error("fifo_rd asserted while fifo_empty");

  a_occ_max: assert property (@(posedge clk) disable iff (!rst_n)
    occ_q <= 2'd2)
    else $error("word buffer occupancy above 2");

  a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_last)))
    else $error("output changed under stall");
`endif

endmodule

// File: tb/tb_fifo_word_unpacker.sv
// Directed bench for fifo_word_unpacker: a RATIO=4 and a RATIO=1 instance, each
// fed by a small behavioural FIFO with registered read data.
module tb_fifo_word_unpacker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic fifo_rst_n;
  int   checks = 0;
  int   errors = 0;

  // FIFO model for the RATIO=4 instance
  logic        f0_wr_en;
  logic [63:0] f0_wr_data;
  logic        f0_rd, f0_empty;
  logic [63:0] f0_word;
  logic [63:0] f0_mem [0:2047];
  logic [11:0] f0_wp, f0_rp;
  int          f0_rd_cnt;
  int          f0_viol = 0;

  assign f0_empty = (f0_wp == f0_rp);

  always @(posedge clk or negedge fifo_rst_n) begin
    if (!fifo_rst_n) begin
      f0_wp <= '0; f0_rp <= '0; f0_word <= '0; f0_rd_cnt <= 0;
    end else begin
      if (f0_wr_en) begin
        f0_mem[f0_wp[10:0]] <= f0_wr_data;
        f0_wp <= f0_wp + 12'd1;
      end
      if (f0_rd) begin
        f0_rd_cnt <= f0_rd_cnt + 1;
        if (!f0_empty) begin
          f0_word <= f0_mem[f0_rp[10:0]];
          f0_rp <= f0_rp + 12'd1;
        end
      end
    end
  end

  // FIFO model for the RATIO=1 instance
  logic        f1_wr_en;
  logic [63:0] f1_wr_data;
  logic        f1_rd, f1_empty;
  logic [63:0] f1_word;
  logic [63:0] f1_mem [0:2047];
  logic [11:0] f1_wp, f1_rp;
  int          f1_rd_cnt;
  int          f1_viol = 0;

  assign f1_empty = (f1_wp == f1_rp);

  always @(posedge clk or negedge fifo_rst_n) begin
    if (!fifo_rst_n) begin
      f1_wp <= '0; f1_rp <= '0; f1_word <= '0; f1_rd_cnt <= 0;
    end else begin
      if (f1_wr_en) begin
        f1_mem[f1_wp[10:0]] <= f1_wr_data;
        f1_wp <= f1_wp + 12'd1;
      end
      if (f1_rd) begin
        f1_rd_cnt <= f1_rd_cnt + 1;
        if (!f1_empty) begin
          f1_word <= f1_mem[f1_rp[10:0]];
          f1_rp <= f1_rp + 12'd1;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (f0_rd && f0_empty) f0_viol <= f0_viol + 1;
    if (f1_rd && f1_empty) f1_viol <= f1_viol + 1;
  end

  logic [15:0] d0_data;
  logic        d0_valid, d0_ready, d0_last;
  logic [63:0] d1_data;
  logic        d1_valid, d1_ready, d1_last;

  fifo_word_unpacker #(.WORD_WDT(64), .RATIO(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .fifo_rd(f0_rd), .fifo_empty(f0_empty),
    .fifo_word(f0_word), .out_data(d0_data), .out_valid(d0_valid),
    .out_ready(d0_ready), .out_last(d0_last)
  );

  fifo_word_unpacker #(.WORD_WDT(64), .RATIO(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .fifo_rd(f1_rd), .fifo_empty(f1_empty),
    .fifo_word(f1_word), .out_data(d1_data), .out_valid(d1_valid),
    .out_ready(d1_ready), .out_last(d1_last)
  );

  // Leaves the DUTs in reset with the FIFO models cleared and running.
  task automatic apply_reset();
    rst_n = 1'b0; fifo_rst_n = 1'b0;
    d0_ready = 1'b0; d1_ready = 1'b0;
    f0_wr_en = 1'b0; f1_wr_en = 1'b0;
    f0_wr_data = '0; f1_wr_data = '0;
    @(negedge clk); @(negedge clk);
    fifo_rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic push0(input logic [63:0] w);
    f0_wr_en = 1'b1; f0_wr_data = w;
    @(negedge clk);
    f0_wr_en = 1'b0;
  endtask

  task automatic push1(input logic [63:0] w);
    f1_wr_en = 1'b1; f1_wr_data = w;
    @(negedge clk);
    f1_wr_en = 1'b0;
  endtask

  task automatic wait_valid0(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (d0_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++; if (d0_valid !== 1'b0) begin errors++; $display("FAIL reset_valid4 got %b want 0", d0_valid); end
    checks++; if (d0_last !== 1'b0) begin errors++; $display("FAIL reset_last4 got %b want 0", d0_last); end
    checks++; if (d0_data !== 16'h0) begin errors++; $display("FAIL reset_data4 got %h want 0", d0_data); end
    checks++; if (d1_valid !== 1'b0 || d1_last !== 1'b0) begin errors++; $display("FAIL reset_ctl1 got %b%b want 00", d1_valid, d1_last); end
    checks++; if (d1_data !== 64'h0) begin errors++; $display("FAIL reset_data1 got %h want 0", d1_data); end
    push0(64'h1111_2222_3333_4444);
    #1;
    checks++; if (f0_rd !== 1'b0) begin errors++; $display("FAIL reset_rd_gated got %b want 0", f0_rd); end
  endtask

  task automatic test_preload4();
    logic [15:0] exp [8];
    logic ok;
    exp = '{16'h0201, 16'h0403, 16'h0605, 16'h0807, 16'h0A09, 16'h0C0B, 16'h0E0D, 16'h100F};
    apply_reset();
    push0(64'h0807060504030201);
    push0(64'h100F0E0D0C0B0A09);
    rst_n = 1'b1; d0_ready = 1'b1;
    wait_valid0(10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL preload_first_valid got timeout want valid"); end
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      checks++;
      if (d0_valid !== 1'b1 || d0_data !== exp[k] || d0_last !== (k % 4 == 3)) begin
        errors++;
        $display("FAIL preload_beat%0d got v=%b d=%h l=%b want v=1 d=%h l=%b", k, d0_valid, d0_data, d0_last, exp[k], (k % 4 == 3));
      end
    end
    @(negedge clk); #1;
    checks++; if (d0_valid !== 1'b0) begin errors++; $display("FAIL preload_drained got %b want 0", d0_valid); end
    checks++; if (f0_rd_cnt !== 2) begin errors++; $display("FAIL preload_rd_pulses got %0d want 2", f0_rd_cnt); end
  endtask

  task automatic test_ratio1_stream();
    logic [63:0] w [16];
    int beats = 0, rd_n = 0, first = -1, last = -1, bubbles = 0;
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      w[i] = 64'hC0DE_0000_0000_0000 | (64'(i) << 16) | 64'(i * 3 + 1);
      push1(w[i]);
    end
    rst_n = 1'b1; d1_ready = 1'b1;
    #1;
    for (int s = 0; s < 25; s++) begin
      if (s > 0) begin @(negedge clk); #1; end
      if (f1_rd) begin
        rd_n++;
        if (first < 0) first = s;
        last = s;
      end
      if (d1_valid && beats < 16) begin
        checks++;
        if (d1_data !== w[beats] || d1_last !== 1'b1) begin
          errors++;
          $display("FAIL r1_beat%0d got d=%h l=%b want d=%h l=1", beats, d1_data, d1_last, w[beats]);
        end
        beats++;
      end else if (!d1_valid && beats > 0 && beats < 16) begin
        bubbles++;
      end
    end
    checks++; if (beats !== 16) begin errors++; $display("FAIL r1_beat_count got %0d want 16", beats); end
    checks++; if (bubbles !== 0) begin errors++; $display("FAIL r1_bubbles got %0d want 0", bubbles); end
    checks++;
    if (rd_n !== 16 || last - first !== 15) begin
      errors++;
      $display("FAIL r1_rd_run got count=%0d span=%0d want count=16 span=15", rd_n, last - first);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] w [5];
    int n = 0;
    apply_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      w[i] = {16'h5000 + 16'(i * 4 + 3), 16'h5000 + 16'(i * 4 + 2), 16'h5000 + 16'(i * 4 + 1), 16'h5000 + 16'(i * 4)};
      push0(w[i]);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (d0_valid) begin
        checks++;
        if (d0_data !== 16'h5000 || d0_last !== 1'b0) begin
          errors++;
          $display("FAIL stall_frozen cyc%0d got d=%h l=%b want d=5000 l=0", c, d0_data, d0_last);
        end
      end
    end
    checks++; if (d0_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got %b want 1", d0_valid); end
    checks++; if (f0_rd_cnt !== 2) begin errors++; $display("FAIL stall_rd_pulses got %0d want 2", f0_rd_cnt); end
    d0_ready = 1'b1;
    for (int c = 0; c < 60 && n < 20; c++) begin
      if (d0_valid) begin
        checks++;
        if (d0_data !== 16'h5000 + 16'(n) || d0_last !== (n % 4 == 3)) begin
          errors++;
          $display("FAIL release_beat%0d got d=%h l=%b want d=%h l=%b", n, d0_data, d0_last, 16'h5000 + 16'(n), (n % 4 == 3));
        end
        n++;
      end
      @(negedge clk); #1;
    end
    checks++; if (n !== 20) begin errors++; $display("FAIL release_count got %0d want 20", n); end
    checks++; if (f0_rd_cnt !== 5) begin errors++; $display("FAIL release_rd_pulses got %0d want 5", f0_rd_cnt); end
  endtask

  task automatic test_single_word();
    logic [63:0] w = 64'hDEAD_BEEF_CAFE_F00D;
    apply_reset();
    rst_n = 1'b1; d0_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (f0_rd !== 1'b0 || d0_valid !== 1'b0) begin errors++; $display("FAIL idle got rd=%b v=%b want 00", f0_rd, d0_valid); end
    @(negedge clk);
    f0_wr_en = 1'b1; f0_wr_data = w;
    @(negedge clk);
    f0_wr_en = 1'b0;
    #1;
    checks++; if (f0_empty !== 1'b0 || f0_rd !== 1'b1 || d0_valid !== 1'b0) begin errors++; $display("FAIL single_c0 got e=%b rd=%b v=%b want 010", f0_empty, f0_rd, d0_valid); end
    @(negedge clk); #1;
    checks++; if (f0_empty !== 1'b1 || f0_rd !== 1'b0 || d0_valid !== 1'b0) begin errors++; $display("FAIL single_c1 got e=%b rd=%b v=%b want 100", f0_empty, f0_rd, d0_valid); end
    @(negedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      checks++;
      if (d0_valid !== 1'b1 || d0_data !== w[16*k +: 16] || f0_rd !== 1'b0) begin
        errors++;
        $display("FAIL single_beat%0d got v=%b d=%h rd=%b want v=1 d=%h rd=0", k, d0_valid, d0_data, f0_rd, w[16*k +: 16]);
      end
    end
    @(negedge clk); #1;
    checks++; if (d0_valid !== 1'b0 || f0_rd_cnt !== 1) begin errors++; $display("FAIL single_end got v=%b pulses=%0d want v=0 pulses=1", d0_valid, f0_rd_cnt); end
  endtask

  task automatic test_random();
    logic [15:0] exp_q [$];
    int got = 0;
    int cyc = 0;
    apply_reset();
    rst_n = 1'b1;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          logic [63:0] w;
          w = {$urandom, $urandom};
          for (int k = 0; k < 4; k++) exp_q.push_back(w[16*k +: 16]);
          push0(w);
          repeat ($urandom_range(0, 1)) @(negedge clk);
        end
      end
      begin
        while (got < 4000 && cyc < 20000) begin
          @(negedge clk);
          d0_ready = 1'($urandom_range(0, 1));
          #1;
          if (d0_valid && d0_ready) begin
            logic [15:0] e;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            checks++;
            if (d0_data !== e || d0_last !== (got % 4 == 3)) begin
              errors++;
              $display("FAIL random_beat%0d got d=%h l=%b want d=%h l=%b", got, d0_data, d0_last, e, (got % 4 == 3));
            end
            got++;
          end
          cyc++;
        end
      end
    join
    checks++; if (got !== 4000) begin errors++; $display("FAIL random_count got %0d want 4000", got); end
    d0_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [63:0] w [3];
    logic [63:0] nw = 64'h0A0B_0C0D_0E0F_1011;
    logic ok;
    w[0] = 64'h0004_0003_0002_0001; w[1] = 64'h0008_0007_0006_0005; w[2] = 64'h000C_000B_000A_0009;
    apply_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) push0(w[i]);
    wait_valid0(10, ok);
    checks++; if (!ok || d0_data !== 16'h0001) begin errors++; $display("FAIL ares_first got ok=%b d=%h want ok=1 d=0001", ok, d0_data); end
    d0_ready = 1'b1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    d0_ready = 1'b0;
    checks++; if (d0_data !== 16'h0003 || d0_valid !== 1'b1) begin errors++; $display("FAIL ares_idx2 got v=%b d=%h want v=1 d=0003", d0_valid, d0_data); end
    #3;
    rst_n = 1'b0; fifo_rst_n = 1'b0;
    #1;
    checks++;
    if (d0_valid !== 1'b0 || d0_last !== 1'b0 || f0_rd !== 1'b0) begin
      errors++;
      $display("FAIL ares_immediate got v=%b l=%b rd=%b want 000", d0_valid, d0_last, f0_rd);
    end
    @(negedge clk); fifo_rst_n = 1'b1;
    @(negedge clk); rst_n = 1'b1; d0_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (d0_valid !== 1'b0) begin errors++; $display("FAIL ares_quiet got %b want 0", d0_valid); end
    push0(nw);
    wait_valid0(10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ares_restart got timeout want valid"); end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      checks++;
      if (d0_valid !== 1'b1 || d0_data !== nw[16*k +: 16] || d0_last !== (k == 3)) begin
        errors++;
        $display("FAIL ares_beat%0d got v=%b d=%h l=%b want v=1 d=%h l=%b", k, d0_valid, d0_data, d0_last, nw[16*k +: 16], (k == 3));
      end
    end
  endtask

  initial begin
    test_reset();
    test_preload4();
    test_ratio1_stream();
    test_backpressure();
    test_single_word();
    test_random();
    test_async_reset();
    checks++;
    if (f0_viol !== 0 || f1_viol !== 0) begin
      errors++;
      $display("FAIL rd_while_empty got %0d/%0d want 0/0", f0_viol, f1_viol);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
